// File: rtl/aurora_pkg.sv
// Shared types for the Aurora RX frame buffer.
// Stream word layout and write-side FSM states.
package aurora_pkg;

    localparam int AXIS_DATA_W = 64;

    typedef struct packed {
        logic                   last;
        logic [AXIS_DATA_W-1:0] data;
    } axis_word_t;

    typedef enum logic {
        WR_ACCEPT = 1'b0,
        WR_DROP   = 1'b1
    } wr_state_e;

endpackage

// File: rtl/axi_stream_if.sv
// Aurora RX user stream: valid/last/data, no backpressure.
interface axi_stream_if;
    import aurora_pkg::*;

    logic                   valid;
    logic                   last;
    logic [AXIS_DATA_W-1:0] data;

    modport master (output valid, last, data);
    modport slave  (input  valid, last, data);

endinterface

// File: rtl/aurora_sdp_ram.sv
// Simple dual-port RAM, one write port, one registered read port.
module aurora_sdp_ram #(
    parameter int DEPTH = 512,
    parameter int WIDTH = 65
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/aurora_rx_frame_buffer.sv
// Store-and-forward RX frame buffer; overflowing frames are dropped whole.
// Optional counters: define AURORA_RX_FRAME_BUFFER_STATS_EN.
module aurora_rx_frame_buffer
    import aurora_pkg::*;
#(
    parameter int DEPTH = 512
) (
    input  logic                   clk,
    input  logic                   rst_n,
    axi_stream_if.slave            s_axis,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [AXIS_DATA_W-1:0] m_data,
    output logic                   m_last,
    output logic                   frame_drop,
    output logic [$clog2(DEPTH):0] level
`ifdef AURORA_RX_FRAME_BUFFER_STATS_EN
    ,
    output logic [31:0]            frames_rx,
    output logic [31:0]            frames_dropped
`endif
);

    localparam int AW = $clog2(DEPTH);

    typedef logic [AW:0] ptr_t;

    wr_state_e  state, state_nxt;
    ptr_t       wr_ptr, wr_ptr_nxt;
    ptr_t       wr_commit, commit_nxt;
    ptr_t       rd_ptr, rd_ptr_nxt;
    ptr_t       fetch_ptr;
    logic       we, drop_nxt, full;
    logic       re, q_vld, move, xfer;
    axis_word_t wword, q;

    assign full  = (wr_ptr - rd_ptr) == ptr_t'(DEPTH);
    assign wword = {s_axis.last, s_axis.data};

    always_comb begin
        state_nxt  = state;
        wr_ptr_nxt = wr_ptr;
        commit_nxt = wr_commit;
        we         = 1'b0;
        drop_nxt   = 1'b0;
        unique case (state)
            WR_ACCEPT: begin
                if (s_axis.valid) begin
                    if (!full) begin
                        we         = 1'b1;
                        wr_ptr_nxt = wr_ptr + ptr_t'(1);
                        if (s_axis.last) commit_nxt = wr_ptr + ptr_t'(1);
                    end else begin
                        // rewind to discard the partial frame
                        wr_ptr_nxt = wr_commit;
                        drop_nxt   = 1'b1;
                        if (!s_axis.last) state_nxt = WR_DROP;
                    end
                end
            end
            WR_DROP: begin
                if (s_axis.valid && s_axis.last) state_nxt = WR_ACCEPT;
            end
            default: state_nxt = WR_ACCEPT;
        endcase
    end

    // rd_ptr frees RAM only on consumption; fetch_ptr runs ahead by up to two
    assign xfer       = m_valid && m_ready;
    assign move       = q_vld && (!m_valid || m_ready);
    assign re         = (fetch_ptr != wr_commit) && (!q_vld || move);
    assign rd_ptr_nxt = rd_ptr + ptr_t'(xfer);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= WR_ACCEPT;
            wr_ptr     <= '0;
            wr_commit  <= '0;
            rd_ptr     <= '0;
            fetch_ptr  <= '0;
            q_vld      <= 1'b0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_last     <= 1'b0;
            frame_drop <= 1'b0;
            level      <= '0;
        end else begin
            state      <= state_nxt;
            wr_ptr     <= wr_ptr_nxt;
            wr_commit  <= commit_nxt;
            rd_ptr     <= rd_ptr_nxt;
            fetch_ptr  <= fetch_ptr + ptr_t'(re);
            q_vld      <= re || (q_vld && !move);
            frame_drop <= drop_nxt;
            level      <= wr_ptr_nxt - rd_ptr_nxt;
            if (move) begin
                m_valid <= 1'b1;
                m_data  <= q.data;
                m_last  <= q.last;
            end else if (xfer) begin
                m_valid <= 1'b0;
            end
        end
    end

`ifdef AURORA_RX_FRAME_BUFFER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frames_rx      <= '0;
            frames_dropped <= '0;
        end else begin
            if (we && s_axis.last) frames_rx <= frames_rx + 32'd1;
            if (drop_nxt) frames_dropped <= frames_dropped + 32'd1;
        end
    end
`endif

    aurora_sdp_ram #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(axis_word_t))
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wword),
        .re    (re),
        .raddr (fetch_ptr[AW-1:0]),
        .rdata (q)
    );

endmodule

// File: tb/tb_aurora_rx_frame_buffer.sv
// Directed and randomised checks of aurora_rx_frame_buffer with DEPTH = 8.
module tb_aurora_rx_frame_buffer;

    localparam int DEPTH = 8;
    typedef logic [$clog2(DEPTH):0] lvl_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m_valid, m_ready, m_last, frame_drop;
    logic [63:0] m_data;
    lvl_t        level;
`ifdef AURORA_RX_FRAME_BUFFER_STATS_EN
    logic [31:0] frames_rx, frames_dropped;
`endif

    axi_stream_if s_if ();

    aurora_rx_frame_buffer #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .s_axis         (s_if),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .m_last         (m_last),
        .frame_drop     (frame_drop),
        .level          (level)
`ifdef AURORA_RX_FRAME_BUFFER_STATS_EN
        ,
        .frames_rx      (frames_rx),
        .frames_dropped (frames_dropped)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    int          mw, mc, mr;
    logic        ms;
    logic        exp_drop;
    logic [64:0] tmpq[$];
    logic [64:0] expq[$];
    logic        stall;
    logic [64:0] stall_word;
    logic        mv_at;
    int          drop_cnt, out_cnt;

    task automatic chk(input string tag, input logic [64:0] obs,
                       input logic [64:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mw = 0; mc = 0; mr = 0; ms = 1'b0;
        exp_drop = 1'b0; stall = 1'b0;
        tmpq.delete(); expq.delete();
    endtask

    task automatic step(input logic v, input logic l,
                        input logic [63:0] d, input logic r);
        logic        drop_n;
        logic        x;
        logic [64:0] w;
        @(negedge clk);
        mv_at = m_valid;
        chk("frame_drop", 65'(frame_drop), 65'(exp_drop));
        chk("level", 65'(level), 65'(lvl_t'(mw - mr)));
        if (stall) begin
            chk("stall_valid", 65'(m_valid), 65'd1);
            chk("stall_word", {m_last, m_data}, stall_word);
        end
        if (frame_drop) drop_cnt++;
        x = m_valid && r;
        if (x) begin
            out_cnt++;
            if (expq.size() == 0) chk("extra_beat", 65'(m_valid), 65'd0);
            else begin
                w = expq.pop_front();
                chk("beat", {m_last, m_data}, w);
            end
        end
        stall      = m_valid && !r;
        stall_word = {m_last, m_data};
        s_if.valid = v;
        s_if.last  = l;
        s_if.data  = d;
        m_ready    = r;
        drop_n = 1'b0;
        if (v) begin
            if (!ms) begin
                if ((mw - mr) == DEPTH) begin
                    drop_n = 1'b1;
                    mw = mc;
                    tmpq.delete();
                    if (!l) ms = 1'b1;
                end else begin
                    tmpq.push_back({l, d});
                    mw++;
                    if (l) begin
                        mc = mw;
                        foreach (tmpq[i]) expq.push_back(tmpq[i]);
                        tmpq.delete();
                    end
                end
            end else if (l) begin
                ms = 1'b0;
            end
        end
        if (x) mr++;
        exp_drop = drop_n;
    endtask

    task automatic send(input int len, input logic [63:0] base, input logic r);
        for (int i = 0; i < len; i++)
            step(1'b1, i == len - 1, base + 64'(i), r);
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 64'd0, 1'b1);
        chk("drain_empty", 65'(expq.size()), 65'd0);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n      = 1'b0;
        s_if.valid = 1'b0;
        s_if.last  = 1'b0;
        s_if.data  = '0;
        m_ready    = 1'b0;
        #1;
        chk("rst_m_valid", 65'(m_valid), 65'd0);
        chk("rst_m_data", 65'(m_data), 65'd0);
        chk("rst_m_last", 65'(m_last), 65'd0);
        chk("rst_drop", 65'(frame_drop), 65'd0);
        chk("rst_level", 65'(level), 65'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n0;
        int len;
        rst_n = 1'b0;
        model_reset();
        reset_dut();

        // 4-word frame, ready high, check FWFT latency
        n0 = out_cnt;
        send(4, 64'h1111_0000_0000_0000, 1'b1);
        step(1'b0, 1'b0, 64'd0, 1'b1);
        chk("lat_edge_n", 65'(mv_at), 65'd0);
        step(1'b0, 1'b0, 64'd0, 1'b1);
        chk("lat_edge_n1", 65'(mv_at), 65'd0);
        step(1'b0, 1'b0, 64'd0, 1'b1);
        chk("lat_edge_n2", 65'(mv_at), 65'd1);
        drain();
        chk("t1_count", 65'(out_cnt - n0), 65'd4);

        // single-word frame
        n0 = out_cnt;
        step(1'b1, 1'b1, 64'hDEAD_BEEF_0000_0001, 1'b1);
        drain();
        chk("t2_count", 65'(out_cnt - n0), 65'd1);

        // A (6) stored, B (4) overflows at beat 3
        n0 = out_cnt;
        drop_cnt = 0;
        send(6, 64'hAAAA_0000_0000_0000, 1'b0);
        send(4, 64'hBBBB_0000_0000_0000, 1'b0);
        step(1'b0, 1'b0, 64'd0, 1'b0);
        chk("t3_level", 65'(level), 65'd6);
        chk("t3_drops", 65'(drop_cnt), 65'd1);
        drain();
        chk("t3_count", 65'(out_cnt - n0), 65'd6);

        // DEPTH+1 words into empty buffer, then 2-word frame
        n0 = out_cnt;
        drop_cnt = 0;
        send(DEPTH + 1, 64'hCCCC_0000_0000_0000, 1'b1);
        drain();
        chk("t4_drops", 65'(drop_cnt), 65'd1);
        chk("t4_count", 65'(out_cnt - n0), 65'd0);
        send(2, 64'hDDDD_0000_0000_0000, 1'b1);
        drain();
        chk("t4_after", 65'(out_cnt - n0), 65'd2);

        // random lengths, random ready
        for (int f = 0; f < 200; f++) begin
            len = int'($urandom_range(1, 20));
            for (int i = 0; i < len; i++)
                step(1'b1, i == len - 1, {$urandom, $urandom},
                     1'($urandom_range(0, 1)));
            for (int g = 0; g < int'($urandom_range(0, 2)); g++)
                step(1'b0, 1'b0, 64'd0, 1'($urandom_range(0, 1)));
        end
        drain();

        // reset while stalled and mid-frame
        send(3, 64'hEEEE_0000_0000_0000, 1'b0);
        repeat (4) step(1'b0, 1'b0, 64'd0, 1'b0);
        chk("pre_rst_valid", 65'(m_valid), 65'd1);
        step(1'b1, 1'b0, 64'h1234, 1'b0);
        step(1'b1, 1'b0, 64'h5678, 1'b0);
        reset_dut();
        n0 = out_cnt;
        send(3, 64'hF00D_0000_0000_0000, 1'b1);
        drain();
        chk("t6_count", 65'(out_cnt - n0), 65'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
